// File: rtl/esc_pwm_array.sv
// N-channel ESC pulse generator with a shared frame counter, an arming sequence
// and a per-frame slew-rate limit on the applied speed of every channel.
module esc_pwm_array #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned SPD_W      = 11,
  parameter int unsigned FRAME_W    = 20,
  parameter int unsigned OFFSET     = 544,
  parameter int unsigned SCALE_SH   = 4,
  parameter int unsigned SLEW       = 64,
  parameter int unsigned ARM_FRAMES = 50
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*SPD_W-1:0]   spd,
  input  logic                      motors_off,
  output logic [NUM_CH-1:0]         pwm,
  output logic                      armed,
  output logic                      frame_tick
);

  // Arming counter must hold ARM_FRAMES and never be zero width.
  localparam int unsigned ARM_W = $clog2(ARM_FRAMES + 2);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ARMED    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] fcnt_q, fcnt_d;
  logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d, arm_cnt_inc;
  logic [SPD_W-1:0]   app_q [NUM_CH];
  logic [SPD_W-1:0]   app_d [NUM_CH];
  logic [NUM_CH-1:0]  pwm_q, pwm_d;
  logic               armed_q, armed_d;
  logic               frame_tick_q, frame_tick_d;
  logic               boundary;

  // One slew-limited step of the applied speed towards the sampled target.
  function automatic logic [SPD_W-1:0] slew_step(input logic [SPD_W-1:0] cur,
                                                 input logic [SPD_W-1:0] tgt);
    logic [SPD_W-1:0] diff;
    diff      = '0;
    slew_step = tgt;
    if (SLEW != 0) begin
      if (tgt > cur) begin
        diff = tgt - cur;
        if (32'(diff) > SLEW) slew_step = cur + SPD_W'(SLEW);
      end else begin
        diff = cur - tgt;
        if (32'(diff) > SLEW) slew_step = cur - SPD_W'(SLEW);
      end
    end
  endfunction

  // Pulse length in clocks for a given applied speed.
  function automatic logic [FRAME_W-1:0] len_of(input logic [SPD_W-1:0] app);
    len_of = (FRAME_W'(app) + FRAME_W'(OFFSET)) << SCALE_SH;
  endfunction

  // Next-state: frame counter, arming FSM, slew update at the boundary, outputs.
  always_comb begin
    fcnt_d       = fcnt_q + FRAME_W'(1);
    state_d      = state_q;
    arm_cnt_d    = arm_cnt_q;
    app_d        = app_q;
    boundary     = (fcnt_q == '1);
    arm_cnt_inc  = arm_cnt_q + ARM_W'(1);
    frame_tick_d = (fcnt_q == '0);
    pwm_d        = '0;

    if (motors_off) begin
      state_d   = ST_DISARMED;
      arm_cnt_d = '0;
      for (int i = 0; i < int'(NUM_CH); i++) app_d[i] = '0;
    end else if (boundary) begin
      case (state_q)
        ST_DISARMED: begin
          state_d   = ST_ARMING;
          arm_cnt_d = '0;
          for (int i = 0; i < int'(NUM_CH); i++) app_d[i] = '0;
        end
        ST_ARMING: begin
          arm_cnt_d = arm_cnt_inc;
          if (32'(arm_cnt_inc) >= ARM_FRAMES) begin
            state_d = ST_ARMED;
            for (int i = 0; i < int'(NUM_CH); i++)
              app_d[i] = slew_step('0, spd[i*SPD_W +: SPD_W]);
          end
        end
        ST_ARMED: begin
          for (int i = 0; i < int'(NUM_CH); i++)
            app_d[i] = slew_step(app_q[i], spd[i*SPD_W +: SPD_W]);
        end
        default: begin
          state_d   = ST_DISARMED;
          arm_cnt_d = '0;
          for (int i = 0; i < int'(NUM_CH); i++) app_d[i] = '0;
        end
      endcase
    end

    armed_d = (state_d == ST_ARMED);
    for (int i = 0; i < int'(NUM_CH); i++)
      pwm_d[i] = (state_d != ST_DISARMED) && (fcnt_q < len_of(app_d[i]));
  end

  // State and output registers; reset clears outputs asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q       <= '0;
      state_q      <= ST_DISARMED;
      arm_cnt_q    <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) app_q[i] <= '0;
      pwm_q        <= '0;
      armed_q      <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      fcnt_q       <= fcnt_d;
      state_q      <= state_d;
      arm_cnt_q    <= arm_cnt_d;
      app_q        <= app_d;
      pwm_q        <= pwm_d;
      armed_q      <= armed_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign pwm        = pwm_q;
  assign armed      = armed_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_esc_pwm_array.sv
// Bench for esc_pwm_array: two instances (SLEW=4 and SLEW=0) driven with the same
// inputs, pulse widths measured per frame and compared with a frame-level model.
module tb_esc_pwm_array;

  localparam int FRAME = 512;
  localparam int OFFS  = 10;
  localparam int ARM_N = 2;
  localparam int M_OFF = 0, M_ARMING = 1, M_ARMED = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] spd = '0;
  logic        motors_off = 1'b1;
  logic [1:0]  pwm_a, pwm_b;
  logic        armed_a, armed_b, tick_a, tick_b;

  int n_chk  = 0;
  int n_fail = 0;

  int m_st  [2];
  int m_cnt [2];
  int m_app [2][2];
  int exp_w [2][2];
  int got_w [2][2];

  esc_pwm_array #(.NUM_CH(2), .SPD_W(8), .FRAME_W(9), .OFFSET(10), .SCALE_SH(0),
                  .SLEW(4), .ARM_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .spd(spd), .motors_off(motors_off),
    .pwm(pwm_a), .armed(armed_a), .frame_tick(tick_a));

  esc_pwm_array #(.NUM_CH(2), .SPD_W(8), .FRAME_W(9), .OFFSET(10), .SCALE_SH(0),
                  .SLEW(0), .ARM_FRAMES(2)) dut_ns (
    .clk(clk), .rst(rst), .spd(spd), .motors_off(motors_off),
    .pwm(pwm_b), .armed(armed_b), .frame_tick(tick_b));

  always #5 clk = ~clk;

  function automatic int step(input int cur, input int tgt, input int sl);
    int d;
    d = tgt - cur;
    if (sl == 0) return tgt;
    if (d > sl) d = sl;
    if (d < -sl) d = -sl;
    return cur + d;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = M_OFF; m_cnt[k] = 0;
      for (int ch = 0; ch < 2; ch++) begin m_app[k][ch] = 0; exp_w[k][ch] = 0; end
    end
  endtask

  // Frame-level model: what happens at the end-of-frame boundary.
  task automatic model_boundary();
    int t, sl;
    for (int k = 0; k < 2; k++) begin
      sl = (k == 0) ? 4 : 0;
      if (motors_off) begin
        m_st[k] = M_OFF; m_cnt[k] = 0; m_app[k][0] = 0; m_app[k][1] = 0;
      end else if (m_st[k] == M_OFF) begin
        m_st[k] = M_ARMING; m_cnt[k] = 0;
      end else if (m_st[k] == M_ARMING) begin
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] >= ARM_N) begin
          m_st[k] = M_ARMED;
          for (int ch = 0; ch < 2; ch++) begin
            t = int'(spd[ch*8 +: 8]);
            m_app[k][ch] = step(0, t, sl);
          end
        end
      end else begin
        for (int ch = 0; ch < 2; ch++) begin
          t = int'(spd[ch*8 +: 8]);
          m_app[k][ch] = step(m_app[k][ch], t, sl);
        end
      end
      for (int ch = 0; ch < 2; ch++)
        exp_w[k][ch] = (m_st[k] == M_OFF) ? 0 : m_app[k][ch] + OFFS;
    end
  endtask

  // Measure one frame starting at a negedge where frame_tick is high.
  task automatic run_frame(input string name, input int chg_at, input logic [15:0] chg_spd,
                           input int on_at, input int off_at);
    int   w [2][2];
    bit   gap [2][2];
    bit   split [2][2];
    int   tk [2];
    int   lim;
    logic p, a;
    for (int k = 0; k < 2; k++) begin
      tk[k] = 0;
      for (int ch = 0; ch < 2; ch++) begin w[k][ch] = 0; gap[k][ch] = 0; split[k][ch] = 0; end
      a = (k == 0) ? armed_a : armed_b;
      n_chk++;
      if (a !== (m_st[k] == M_ARMED)) begin
        n_fail++;
        $display("FAIL %s armed inst%0d: got %b expected %0d", name, k, a, m_st[k] == M_ARMED);
      end
    end
    for (int c = 0; c < FRAME; c++) begin
      for (int k = 0; k < 2; k++)
        for (int ch = 0; ch < 2; ch++) begin
          p = (k == 0) ? pwm_a[ch] : pwm_b[ch];
          if (p === 1'b1) begin
            if (gap[k][ch]) split[k][ch] = 1'b1;
            w[k][ch]++;
          end else gap[k][ch] = 1'b1;
        end
      if (tick_a === 1'b1) tk[0]++;
      if (tick_b === 1'b1) tk[1]++;
      if (c == chg_at) spd = chg_spd;
      if (c == on_at)  motors_off = 1'b0;
      if (c == off_at) motors_off = 1'b1;
      @(negedge clk);
      if (c == off_at) begin
        n_chk++;
        if (pwm_a !== 2'b00 || pwm_b !== 2'b00 || armed_a !== 1'b0 || armed_b !== 1'b0) begin
          n_fail++;
          $display("FAIL %s abort: pwm %b/%b armed %b/%b expected all 0", name, pwm_a, pwm_b,
                   armed_a, armed_b);
        end
      end
    end
    n_chk++;
    if (tk[0] != 1 || tk[1] != 1 || tick_a !== 1'b1 || tick_b !== 1'b1) begin
      n_fail++;
      $display("FAIL %s frame_tick: ticks %0d/%0d next %b/%b expected 1 per 512 clocks", name,
               tk[0], tk[1], tick_a, tick_b);
    end
    for (int k = 0; k < 2; k++)
      for (int ch = 0; ch < 2; ch++) begin
        lim = exp_w[k][ch];
        if (off_at >= 0 && off_at + 1 < lim) lim = off_at + 1;
        n_chk++;
        if (w[k][ch] != lim || split[k][ch]) begin
          n_fail++;
          $display("FAIL %s width inst%0d ch%0d: got %0d (split %0d) expected %0d", name, k, ch,
                   w[k][ch], split[k][ch], lim);
        end
        got_w[k][ch] = w[k][ch];
      end
    model_boundary();
  endtask

  task automatic test_reset();
    rst = 1'b1; motors_off = 1'b1; spd = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (pwm_a !== 2'b00 || pwm_b !== 2'b00 || armed_a !== 1'b0 || tick_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pwm %b armed %b tick %b expected 0", pwm_a, armed_a, tick_a);
    end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (tick_a !== 1'b1 || tick_b !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_tick: got %b/%b expected 1", tick_a, tick_b);
    end
    model_reset();
    run_frame("reset_frame", -1, '0, -1, -1);
  endtask

  task automatic test_arming();
    int e;
    motors_off = 1'b0; spd = {8'd50, 8'd50};
    run_frame("arm_off", -1, '0, -1, -1);
    for (int f = 0; f < 2; f++) begin
      run_frame("arming", -1, '0, -1, -1);
      n_chk++;
      if (got_w[0][0] != 10 || got_w[0][1] != 10 || got_w[1][0] != 10) begin
        n_fail++;
        $display("FAIL arming_width: got %0d %0d %0d expected 10", got_w[0][0], got_w[0][1],
                 got_w[1][0]);
      end
    end
    n_chk++;
    if (armed_a !== 1'b1) begin
      n_fail++;
      $display("FAIL armed_flag: got %b expected 1", armed_a);
    end
    for (int f = 1; f <= 14; f++) begin
      run_frame("ramp", -1, '0, -1, -1);
      e = (10 + 4 * f > 60) ? 60 : 10 + 4 * f;
      n_chk++;
      if (got_w[0][0] != e || got_w[0][1] != e || got_w[1][1] != 60) begin
        n_fail++;
        $display("FAIL ramp_width f%0d: got %0d %0d ns %0d expected %0d and 60", f,
                 got_w[0][0], got_w[0][1], got_w[1][1], e);
      end
    end
  endtask

  task automatic test_slew();
    int down [4] = '{60, 56, 52, 50};
    int up   [3] = '{50, 54, 58};
    for (int f = 0; f < 4; f++) begin
      run_frame("slew_down", (f == 0) ? 0 : -1, {8'd40, 8'd40}, -1, -1);
      n_chk++;
      if (got_w[0][0] != down[f] || got_w[0][1] != down[f]) begin
        n_fail++;
        $display("FAIL slew_down f%0d: got %0d %0d expected %0d", f, got_w[0][0], got_w[0][1],
                 down[f]);
      end
    end
    for (int f = 0; f < 3; f++) begin
      run_frame("slew_up", (f == 0) ? 20 : -1, {8'd80, 8'd80}, -1, -1);
      n_chk++;
      if (got_w[0][0] != up[f]) begin
        n_fail++;
        $display("FAIL slew_up f%0d: got %0d expected %0d", f, got_w[0][0], up[f]);
      end
    end
  endtask

  task automatic test_abort();
    run_frame("abort", -1, '0, -1, 30);
    n_chk++;
    if (got_w[0][0] != 31 || got_w[1][0] != 31) begin
      n_fail++;
      $display("FAIL abort_width: got %0d %0d expected 31", got_w[0][0], got_w[1][0]);
    end
    run_frame("held_off", -1, '0, -1, -1);
    run_frame("toggle", -1, '0, 100, 300);
    run_frame("after_toggle", -1, '0, -1, -1);
    n_chk++;
    if (got_w[0][0] != 0 || got_w[1][1] != 0) begin
      n_fail++;
      $display("FAIL toggle_no_pulse: got %0d %0d expected 0", got_w[0][0], got_w[1][1]);
    end
    motors_off = 1'b0;
    run_frame("rearm_off", -1, '0, -1, -1);
    for (int f = 0; f < 3; f++) begin
      run_frame("rearm", -1, '0, -1, -1);
      n_chk++;
      if (got_w[0][0] != ((f < 2) ? 10 : 14)) begin
        n_fail++;
        $display("FAIL rearm f%0d: got %0d expected %0d", f, got_w[0][0], (f < 2) ? 10 : 14);
      end
    end
  endtask

  task automatic test_extremes();
    run_frame("ext_kill", -1, '0, -1, 0);
    motors_off = 1'b0; spd = {8'd255, 8'd0};
    for (int f = 0; f < 3; f++) run_frame("ext_arm", -1, '0, -1, -1);
    for (int f = 0; f < 2; f++) begin
      run_frame("extremes", -1, '0, -1, -1);
      n_chk++;
      if (got_w[1][0] != 10 || got_w[1][1] != 265) begin
        n_fail++;
        $display("FAIL extremes f%0d: got %0d %0d expected 10 265", f, got_w[1][0], got_w[1][1]);
      end
    end
  endtask

  task automatic test_independence();
    int c1 [3] = '{14, 18, 18};
    int c0 [7] = '{10, 14, 18, 22, 26, 30, 30};
    run_frame("ind_kill", -1, '0, -1, 0);
    motors_off = 1'b0; spd = {8'd8, 8'd0};
    for (int f = 0; f < 3; f++) run_frame("ind_arm", -1, '0, -1, -1);
    for (int f = 0; f < 3; f++) begin
      run_frame("ind_settle", -1, '0, -1, -1);
      n_chk++;
      if (got_w[0][1] != c1[f] || got_w[0][0] != 10) begin
        n_fail++;
        $display("FAIL ind_settle f%0d: got %0d %0d expected 10 %0d", f, got_w[0][0],
                 got_w[0][1], c1[f]);
      end
    end
    for (int f = 0; f < 7; f++) begin
      run_frame("ind_ramp", (f == 0) ? 0 : -1, {8'd8, 8'd20}, -1, -1);
      n_chk++;
      if (got_w[0][0] != c0[f] || got_w[0][1] != 18) begin
        n_fail++;
        $display("FAIL ind_ramp f%0d: got %0d %0d expected %0d 18", f, got_w[0][0],
                 got_w[0][1], c0[f]);
      end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    #1;
    n_chk++;
    if (pwm_a !== 2'b00 || pwm_b !== 2'b00 || armed_a !== 1'b0 || tick_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: pwm %b/%b armed %b tick %b expected 0", pwm_a, pwm_b, armed_a,
               tick_a);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (tick_a !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_tick: got %b expected 1", tick_a);
    end
    model_reset();
    run_frame("post_reset", -1, '0, -1, -1);
  endtask

  task automatic test_random();
    int chg_at, on_at, off_at, r;
    logic [15:0] ns;
    for (int n = 0; n < 24; n++) begin
      chg_at = -1; on_at = -1; off_at = -1;
      r  = int'($urandom_range(0, 7));
      ns = 16'($urandom);
      if (motors_off) begin
        if (r < 5) on_at = int'($urandom_range(0, 400));
        if (r == 0) off_at = on_at + int'($urandom_range(1, 100));
      end else if (r == 0) begin
        off_at = int'($urandom_range(0, 500));
      end
      if ($urandom_range(0, 1) == 1) chg_at = int'($urandom_range(0, 500));
      run_frame("random", chg_at, ns, on_at, off_at);
    end
  endtask

  initial begin
    test_reset();
    test_arming();
    test_slew();
    test_abort();
    test_extremes();
    test_independence();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
